// File: rtl/timer_ctrl.sv
// ---------------------------------------------------------------------------
// timer_ctrl
//
// This is a prescaled step timer with one-shot and periodic modes, and pause
// and stop control.
//
// Once a start is accepted, the timer counts in steps of PRESCALE clock
// cycles. When the count reaches the latched period it wraps to 0 and pulses
// o_done for one cycle. In one-shot mode the timer then returns to idle. In
// periodic mode it reloads with no dead cycle.
//
// Each edge gives the inputs this priority: stop > start > pause.
// All outputs are registered.
//
// Parameters
//   PRESCALE    clock cycles per count step; legal range 1..255
//
// Ports
//   i_clk       clock; all state changes happen on the rising edge
//   i_rst_n     asynchronous reset, active low
//   i_start     level input; loads i_period and begins timing
//               (rejected with o_err when i_period is 0)
//   i_stop      level input; aborts timing, clears the count, no done
//   i_pause     level input; freezes timing while in RUN
//   i_periodic  1 = auto-reload at terminal count, 0 = one-shot
//   i_period    terminal count in steps; sampled only when start is accepted
//   o_count     current step count (always < latched period)
//   o_busy      high while in RUN or PAUSE
//   o_done      one-cycle pulse after the terminal count
//   o_err       one-cycle pulse when start is rejected
// ---------------------------------------------------------------------------
module timer_ctrl #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_pause,
  input  logic       i_periodic,
  input  logic [6:0] i_period,
  output logic [6:0] o_count,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

  state_t     r_state;
  logic [6:0] r_count;
  logic [6:0] r_period;
  logic [7:0] r_presc;
  logic       r_busy;
  logic       r_done;
  logic       r_err;

  logic       w_step;
  logic       w_terminal;

  // A step strobe fires on the last prescaler cycle. The terminal count is
  // a strobe that lands on the final count value of the latched period.
  assign w_step     = (r_presc == PRESC_LAST);
  assign w_terminal = w_step && (r_count == (r_period - 7'd1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_count  <= 7'd0;
      r_period <= 7'd0;
      r_presc  <= 8'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      if (i_stop) begin
        // Stop wins over everything, including a coinciding terminal
        // strobe, so no done is produced.
        r_state <= ST_IDLE;
        r_count <= 7'd0;
        r_presc <= 8'd0;
        r_busy  <= 1'b0;
      end else if (i_start) begin
        if (i_period == 7'd0) begin
          // The start is rejected. Timing is frozen for this edge, and the
          // state, count and period stay as they were.
          r_err <= 1'b1;
        end else begin
          // This covers a fresh start and a restart from RUN or PAUSE alike.
          r_period <= i_period;
          r_count  <= 7'd0;
          r_presc  <= 8'd0;
          r_state  <= ST_RUN;
          r_busy   <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end

          ST_RUN, ST_PAUSE: begin
            if (i_pause) begin
              r_state <= ST_PAUSE;
            end else begin
              // Leaving PAUSE counts on the same edge. Because of this, the
              // delay equals exactly the number of edges that sampled
              // pause high.
              r_state <= ST_RUN;
              if (w_step) begin
                r_presc <= 8'd0;
                if (w_terminal) begin
                  r_count <= 7'd0;
                  r_done  <= 1'b1;
                  if (!i_periodic) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                  end
                end else begin
                  r_count <= r_count + 7'd1;
                end
              end else begin
                r_presc <= r_presc + 8'd1;
              end
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_count = r_count;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_err   = r_err;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed testbench for timer_ctrl.
// Two instances share all inputs: one with PRESCALE=1 and one with PRESCALE=3.
// Each scenario checks only the instance it is aimed at.
module tb_timer_ctrl;

  logic       clk;
  logic       rstN;
  logic       start;
  logic       stop;
  logic       pause;
  logic       periodic;
  logic [6:0] period;

  logic [6:0] count1, count3;
  logic       busy1, busy3;
  logic       done1, done3;
  logic       err1, err3;

  int total = 0;
  int bad   = 0;

  timer_ctrl #(.PRESCALE(1)) dut1 (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_start    (start),
    .i_stop     (stop),
    .i_pause    (pause),
    .i_periodic (periodic),
    .i_period   (period),
    .o_count    (count1),
    .o_busy     (busy1),
    .o_done     (done1),
    .o_err      (err1)
  );

  timer_ctrl #(.PRESCALE(3)) dut3 (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_start    (start),
    .i_stop     (stop),
    .i_pause    (pause),
    .i_periodic (periodic),
    .i_period   (period),
    .o_count    (count3),
    .o_busy     (busy3),
    .o_done     (done3),
    .o_err      (err3)
  );

  // The clock has a 10-unit period, with rising edges at 5, 15, 25 and so on.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // This watchdog guarantees that the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Every comparison goes through here. It counts the comparison and
  // reports any mismatch.
  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", tag, obs, exp);
    end
  endtask

  // This drives all control inputs at once.
  task automatic applyStimulus(input logic st, input logic sp, input logic pa,
                               input logic per, input logic [6:0] prd);
    start    = st;
    stop     = sp;
    pause    = pa;
    periodic = per;
    period   = prd;
  endtask

  // This advances one rising edge and settles 1 time unit past it, where
  // outputs are sampled and new inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // This returns both instances to IDLE and leaves all inputs low.
  task automatic goIdle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);

    // Reset state
    #2;
    checkOutput("rst_count", int'(count1), 0);
    checkOutput("rst_busy",  int'(busy1), 0);
    checkOutput("rst_done",  int'(done1), 0);
    checkOutput("rst_err",   int'(err1), 0);
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // One-shot, PRESCALE=1, period=5: count goes 1,2,3,4,0, and done and the
    // fall of busy both come on edge 5.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd5);
    tick();
    checkOutput("os_start_busy", int'(busy1), 1);
    checkOutput("os_start_count", int'(count1), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd5);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput($sformatf("os_count_e%0d", k), int'(count1), k % 5);
      checkOutput($sformatf("os_done_e%0d", k), int'(done1), (k == 5) ? 1 : 0);
      checkOutput($sformatf("os_busy_e%0d", k), int'(busy1), (k == 5) ? 0 : 1);
    end
    tick();
    checkOutput("os_done_after", int'(done1), 0);
    goIdle();

    // Periodic, PRESCALE=3, period=2: done comes every 6 edges for 4
    // periods, and busy stays high throughout.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 7'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd2);
    for (int k = 1; k <= 24; k++) begin
      tick();
      checkOutput($sformatf("per_done_e%0d", k), int'(done3), (k % 6 == 0) ? 1 : 0);
      checkOutput($sformatf("per_busy_e%0d", k), int'(busy3), 1);
      checkOutput($sformatf("per_count_e%0d", k), int'(count3), (k / 3) % 2);
    end
    goIdle();
    checkOutput("per_stop_busy", int'(busy3), 0);

    // period=4, pause held for 3 edges at count=2: done moves from edge 4 to
    // edge 7.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd4);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd4);
    tick();
    tick();
    checkOutput("pau_count_pre", int'(count1), 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'd4);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("pau_hold_%0d", k), int'(count1), 2);
      checkOutput($sformatf("pau_busy_%0d", k), int'(busy1), 1);
      checkOutput($sformatf("pau_done_%0d", k), int'(done1), 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd4);
    tick();
    checkOutput("pau_resume_count", int'(count1), 3);
    checkOutput("pau_resume_done", int'(done1), 0);
    tick();
    checkOutput("pau_done", int'(done1), 1);
    checkOutput("pau_end_count", int'(count1), 0);
    checkOutput("pau_end_busy", int'(busy1), 0);
    goIdle();

    // Stop on the terminal-count edge produces no done, and count ends at 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd3);
    tick();
    tick();
    checkOutput("stp_count_pre", int'(count1), 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd3);
    tick();
    checkOutput("stp_done", int'(done1), 0);
    checkOutput("stp_count", int'(count1), 0);
    checkOutput("stp_busy", int'(busy1), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd3);
    tick();
    checkOutput("stp_done_after", int'(done1), 0);

    // A start with period=0 from IDLE is rejected.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    tick();
    checkOutput("err_idle_err", int'(err1), 1);
    checkOutput("err_idle_busy", int'(busy1), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    tick();
    checkOutput("err_idle_clear", int'(err1), 0);

    // A start with period=0 is rejected in RUN too, without disturbing the
    // count. A restart with period=3 then gives its first done 3 edges later.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd5);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd5);
    tick();
    checkOutput("rs_count1", int'(count1), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    tick();
    checkOutput("rs_err_run", int'(err1), 1);
    checkOutput("rs_err_count", int'(count1), 1);
    checkOutput("rs_err_busy", int'(busy1), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd3);
    tick();
    checkOutput("rs_restart_count", int'(count1), 0);
    checkOutput("rs_restart_done", int'(done1), 0);
    checkOutput("rs_restart_err", int'(err1), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd3);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput($sformatf("rs_done_e%0d", k), int'(done1), (k == 3) ? 1 : 0);
      checkOutput($sformatf("rs_count_e%0d", k), int'(count1), k % 3);
    end
    goIdle();

    // period=127 runs to its full length without wrapping early.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd127);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd127);
    for (int k = 1; k <= 126; k++) tick();
    checkOutput("max_count126", int'(count1), 126);
    checkOutput("max_done126", int'(done1), 0);
    tick();
    checkOutput("max_done127", int'(done1), 1);
    checkOutput("max_count127", int'(count1), 0);
    goIdle();

    // An asynchronous reset at count=60 clears outputs immediately. The first
    // edge after release then samples start.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd127);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd127);
    for (int k = 1; k <= 60; k++) tick();
    checkOutput("ar_count60", int'(count1), 60);
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("ar_count", int'(count1), 0);
    checkOutput("ar_busy", int'(busy1), 0);
    checkOutput("ar_done", int'(done1), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd2);
    #2;
    rstN = 1'b1;
    tick();
    checkOutput("ar_restart_busy", int'(busy1), 1);
    checkOutput("ar_restart_count", int'(count1), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd2);
    tick();
    checkOutput("ar_e1_count", int'(count1), 1);
    checkOutput("ar_e1_done", int'(done1), 0);
    tick();
    checkOutput("ar_e2_done", int'(done1), 1);
    checkOutput("ar_e2_busy", int'(busy1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
